// File: rtl/cache_pkg.sv
// Shared types and default geometry for the L2 set store.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package cache_pkg;

    localparam int DEF_INDEX_BITS = 14;
    localparam int DEF_TAG_BITS   = 12;
    localparam int DEF_LINE_BITS  = 512;
    localparam int DEF_WAYS       = 8;
    localparam int DEF_WAY_BITS   = $clog2(DEF_WAYS);

    typedef enum logic [1:0] {
        MESI_I = 2'd0,
        MESI_S = 2'd1,
        MESI_E = 2'd2,
        MESI_M = 2'd3
    } mesi_t;

    typedef enum logic [1:0] {
        OP_READ  = 2'd0,
        OP_WRITE = 2'd1,
        OP_FILL  = 2'd2,
        OP_SNOOP = 2'd3
    } op_t;

    // One way of one set at the default geometry.
    typedef struct packed {
        logic [DEF_TAG_BITS-1:0]  tag;
        logic [DEF_LINE_BITS-1:0] data;
        mesi_t                    mesi;
        logic [DEF_WAY_BITS-1:0]  age;
    } way_entry_t;

    // A fill may only install a clean state; anything other than E becomes S.
    function automatic mesi_t fillState(input logic [1:0] requested);
        return (requested == MESI_E) ? MESI_E : MESI_S;
    endfunction

endpackage

// File: rtl/cache_lru.sv
// True-LRU helper: picks a victim way and computes post-touch ages.
// Latency: purely combinational.
// Backpressure: none; evaluated on whatever set the parent presents.
module cache_lru #(
    parameter int WAYS  = 4,
    parameter int AGE_W = $clog2(WAYS)
) (
    input  logic [WAYS-1:0][AGE_W-1:0] ages,
    input  logic [WAYS-1:0]            validBits,
    input  logic [AGE_W-1:0]           touchedWay,
    output logic [AGE_W-1:0]           victimWay,
    output logic [WAYS-1:0][AGE_W-1:0] nextAges
);

    logic             foundFree;
    logic [AGE_W-1:0] touchedAge;

    // Victim: lowest-numbered invalid way, otherwise the oldest way (age all ones).
    always_comb begin
        victimWay = '0;
        foundFree = 1'b0;
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (!validBits[w]) begin
                victimWay = AGE_W'(w);
                foundFree = 1'b1;
            end
        end
        if (!foundFree) begin
            for (int w = 0; w < WAYS; w++) begin
                if (ages[w] == {AGE_W{1'b1}}) begin
                    victimWay = AGE_W'(w);
                end
            end
        end
    end

    // Touched way becomes age 0; every younger way ages by one, keeping a permutation.
    always_comb begin
        touchedAge = ages[touchedWay];
        for (int w = 0; w < WAYS; w++) begin
            if (AGE_W'(w) == touchedWay) begin
                nextAges[w] = '0;
            end else if (ages[w] < touchedAge) begin
                nextAges[w] = ages[w] + 1'b1;
            end else begin
                nextAges[w] = ages[w];
            end
        end
    end

endmodule

// File: rtl/cache_set_store.sv
// L2 set store: tag/data/MESI/LRU per way; serves READ, WRITE, FILL and SNOOP.
// Latency: response strobe two cycles after acceptance; one request per three cycles.
// Backpressure: req_ready only in IDLE; requests offered otherwise are ignored, not buffered.
module cache_set_store
    import cache_pkg::*;
#(
    parameter int INDEX_BITS = DEF_INDEX_BITS,
    parameter int TAG_BITS   = DEF_TAG_BITS,
    parameter int LINE_BITS  = DEF_LINE_BITS,
    parameter int WAYS       = DEF_WAYS
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic [1:0]              req_op,
    input  logic [INDEX_BITS-1:0]   req_index,
    input  logic [TAG_BITS-1:0]     req_tag,
    input  logic [LINE_BITS-1:0]    req_data,
    input  logic [1:0]              req_fill_mesi,
    input  logic                    req_snoop_inv,
    output logic                    resp_valid,
    output logic                    resp_hit,
    output logic [$clog2(WAYS)-1:0] resp_way,
    output logic [LINE_BITS-1:0]    resp_data,
    output logic [1:0]              resp_mesi,
    output logic                    evict_valid,
    output logic [TAG_BITS-1:0]     evict_tag,
    output logic [LINE_BITS-1:0]    evict_data
);

    localparam int SETS  = 2 ** INDEX_BITS;
    localparam int WAY_W = $clog2(WAYS);

    typedef enum logic [1:0] {ST_INIT, ST_IDLE, ST_LOOKUP, ST_UPDATE} state_t;

    state_t                  state, nextState;
    logic [INDEX_BITS-1:0]   initCnt;

    op_t                     reqOp;
    logic [INDEX_BITS-1:0]   reqIndex;
    logic [TAG_BITS-1:0]     reqTag;
    logic [LINE_BITS-1:0]    reqData;
    mesi_t                   reqFillMesi;
    logic                    reqSnoopInv;

    logic                    lkHit;
    logic [WAY_W-1:0]        lkWay;

    logic [TAG_BITS-1:0]     tagMem  [SETS][WAYS];
    logic [LINE_BITS-1:0]    dataMem [SETS][WAYS];
    mesi_t                   mesiMem [SETS][WAYS];
    logic [WAY_W-1:0]        ageMem  [SETS][WAYS];

    logic [WAYS-1:0][WAY_W-1:0] setAges, nextAges;
    logic [WAYS-1:0]         setValid;
    logic                    hitAny;
    logic [WAY_W-1:0]        hitWay, victimWay;

    logic [TAG_BITS-1:0]     tgtTag;
    logic [LINE_BITS-1:0]    tgtData;
    mesi_t                   tgtMesi;
    logic                    isAlloc, doTouch, evictNow;

    assign req_ready = (state == ST_IDLE);
    assign isAlloc   = (reqOp == OP_WRITE) || (reqOp == OP_FILL);
    assign doTouch   = isAlloc || ((reqOp == OP_READ) && lkHit);
    assign tgtTag    = tagMem[reqIndex][lkWay];
    assign tgtData   = dataMem[reqIndex][lkWay];
    assign tgtMesi   = mesiMem[reqIndex][lkWay];
    assign evictNow  = isAlloc && !lkHit && (tgtMesi == MESI_M);

    // State register; reset always restarts the set-clearing sweep.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_INIT;
        end else begin
            state <= nextState;
        end
    end

    // Next-state: sweep sets, wait for a request, then lookup and update.
    always_comb begin
        nextState = state;
        case (state)
            ST_INIT:   if (&initCnt) nextState = ST_IDLE;
            ST_IDLE:   if (req_valid) nextState = ST_LOOKUP;
            ST_LOOKUP: nextState = ST_UPDATE;
            ST_UPDATE: nextState = ST_IDLE;
            default:   nextState = ST_INIT;
        endcase
    end

    // Sweep counter, request capture at acceptance, and lookup result capture.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            initCnt     <= '0;
            reqOp       <= OP_READ;
            reqIndex    <= '0;
            reqTag      <= '0;
            reqData     <= '0;
            reqFillMesi <= MESI_S;
            reqSnoopInv <= 1'b0;
            lkHit       <= 1'b0;
            lkWay       <= '0;
        end else begin
            if (state == ST_INIT) begin
                initCnt <= initCnt + 1'b1;
            end
            if (state == ST_IDLE && req_valid) begin
                reqOp       <= op_t'(req_op);
                reqIndex    <= req_index;
                reqTag      <= req_tag;
                reqData     <= req_data;
                reqFillMesi <= fillState(req_fill_mesi);
                reqSnoopInv <= req_snoop_inv;
            end
            if (state == ST_LOOKUP) begin
                lkHit <= hitAny;
                lkWay <= hitAny ? hitWay : (isAlloc ? victimWay : '0);
            end
        end
    end

    // Tag compare across the valid ways of the requested set.
    always_comb begin
        hitAny = 1'b0;
        hitWay = '0;
        for (int w = 0; w < WAYS; w++) begin
            setAges[w]  = ageMem[reqIndex][w];
            setValid[w] = (mesiMem[reqIndex][w] != MESI_I);
            if (setValid[w] && tagMem[reqIndex][w] == reqTag) begin
                hitAny = 1'b1;
                hitWay = WAY_W'(w);
            end
        end
    end

    cache_lru #(.WAYS(WAYS), .AGE_W(WAY_W)) u_lru (
        .ages       (setAges),
        .validBits  (setValid),
        .touchedWay (lkWay),
        .victimWay  (victimWay),
        .nextAges   (nextAges)
    );

    // Array writes: clear one set per cycle in INIT, apply the op's effect in UPDATE.
    always_ff @(posedge clk) begin
        if (state == ST_INIT) begin
            for (int w = 0; w < WAYS; w++) begin
                mesiMem[initCnt][w] <= MESI_I;
                ageMem[initCnt][w]  <= WAY_W'(w);
            end
        end else if (state == ST_UPDATE) begin
            if (doTouch) begin
                for (int w = 0; w < WAYS; w++) begin
                    ageMem[reqIndex][w] <= nextAges[w];
                end
            end
            if (isAlloc) begin
                tagMem[reqIndex][lkWay]  <= reqTag;
                dataMem[reqIndex][lkWay] <= reqData;
                mesiMem[reqIndex][lkWay] <= (reqOp == OP_WRITE) ? MESI_M : reqFillMesi;
            end else if (reqOp == OP_SNOOP && lkHit) begin
                mesiMem[reqIndex][lkWay] <= reqSnoopInv ? MESI_I : MESI_S;
            end
        end
    end

    // Registered response: pre-op view of the target way, strobed for one cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            resp_valid  <= 1'b0;
            resp_hit    <= 1'b0;
            resp_way    <= '0;
            resp_data   <= '0;
            resp_mesi   <= MESI_I;
            evict_valid <= 1'b0;
            evict_tag   <= '0;
            evict_data  <= '0;
        end else if (state == ST_UPDATE) begin
            resp_valid  <= 1'b1;
            resp_hit    <= lkHit;
            resp_way    <= lkWay;
            resp_data   <= lkHit ? tgtData : '0;
            resp_mesi   <= lkHit ? tgtMesi : MESI_I;
            evict_valid <= evictNow;
            evict_tag   <= evictNow ? tgtTag : '0;
            evict_data  <= evictNow ? tgtData : '0;
        end else begin
            resp_valid  <= 1'b0;
            resp_hit    <= 1'b0;
            resp_way    <= '0;
            resp_data   <= '0;
            resp_mesi   <= MESI_I;
            evict_valid <= 1'b0;
            evict_tag   <= '0;
            evict_data  <= '0;
        end
    end

endmodule
